// File: rtl/set_bit_iter_if.sv
// Handshake bundle for set_bit_iter: a vector-in channel, an index-out
// channel, flush, and status. The slave modport is the iterator itself.
interface set_bit_iter_if #(
  parameter int WIDTH = 8
);
  localparam int IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CntW = $clog2(WIDTH + 1);

  logic             flush_i;
  logic [WIDTH-1:0] vec_i;
  logic             vec_valid_i;
  logic             vec_ready_o;
  logic [IdxW-1:0]  idx_o;
  logic             last_o;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic             busy_o;
  logic [CntW-1:0]  count_o;
  logic             state_dbg;   // 1 while the FSM is in SCAN

  modport master (
    output flush_i, vec_i, vec_valid_i, idx_ready_i,
    input  vec_ready_o, idx_o, last_o, idx_valid_o, busy_o, count_o, state_dbg
  );

  modport slave (
    input  flush_i, vec_i, vec_valid_i, idx_ready_i,
    output vec_ready_o, idx_o, last_o, idx_valid_o, busy_o, count_o, state_dbg
  );
endinterface

// File: rtl/set_bit_iter.sv
// Set-bit iterator: accepts a vector and emits the positions of its set bits
// one per handshake, lowest first (MODE=0) or highest first (MODE=1).
//
// Handshakes: a transfer happens on a channel in any cycle where valid and
// ready are both 1 on the rising edge. vec_ready_o is only high in IDLE, so a
// new vector cannot be taken in the same cycle as the final index. flush_i
// overrides both channels in the cycle it is high.
module set_bit_iter #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0
) (
  input logic          clk_i,
  input logic          rst_i,
  set_bit_iter_if.slave bus
);
  localparam int IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  sel_idx;
  logic             single;
  logic             in_scan;

  // Priority pick of the next index: the last match in loop order wins.
  always_comb begin
    sel_idx = '0;
    if (MODE == 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pend_q[i]) sel_idx = IdxW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pend_q[i]) sel_idx = IdxW'(i);
      end
    end
  end

  // Exactly one bit left means the current index is the final one.
  assign single  = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);
  assign in_scan = (state_q == SCAN);

  assign bus.vec_ready_o = !in_scan && !bus.flush_i;
  assign bus.idx_valid_o = in_scan;
  assign bus.busy_o      = in_scan;
  assign bus.idx_o       = in_scan ? sel_idx : '0;
  assign bus.last_o      = in_scan && single;
  assign bus.count_o     = cnt_q;
  assign bus.state_dbg   = in_scan;

  // Next-state, pending and count update; flush overrides everything.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      pend_d  = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (bus.vec_valid_i) begin
        cnt_d = '0;
        if (bus.vec_i != '0) begin
          pend_d  = bus.vec_i;
          state_d = SCAN;
        end
      end
    end else begin
      if (bus.idx_ready_i) begin
        pend_d = pend_q & ~(WIDTH'(1) << sel_idx);
        cnt_d  = cnt_q + CntW'(1);
        if (single) state_d = IDLE;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/set_bit_iter.md
SET_BIT_ITER -- requirements
Module: set_bit_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning width of the scanned vector (>=1).
REQ-002 SHALL have parameter MODE, default 0: 0 = emit set-bit indices ascending from LSB; 1 = descending from MSB.
REQ-003 SHALL derive IdxW = max(1, $clog2(WIDTH)) and CntW = $clog2(WIDTH+1); these are not overridable.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 flush_i  input  1  synchronous abort of the current vector.
REQ-007 vec_i  input  WIDTH  vector to scan.
REQ-008 vec_valid_i  input  1  vec_i valid.
REQ-009 vec_ready_o  output  1  block accepts vec_i.
REQ-010 idx_o  output  IdxW  absolute bit position of the current set bit.
REQ-011 last_o  output  1  idx_o is the final set bit of the vector.
REQ-012 idx_valid_o  output  1  idx_o/last_o valid.
REQ-013 idx_ready_i  input  1  consumer takes idx_o.
REQ-014 busy_o  output  1  a vector is being scanned.
REQ-015 count_o  output  CntW  indices handshaken for the current vector.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and SCAN, with a WIDTH-bit pending register.
REQ-017 In IDLE, vec_ready_o SHALL be 1 when flush_i=0, and 0 when flush_i=1; in SCAN, vec_ready_o SHALL be 0.
REQ-018 On vec_valid_i & vec_ready_o with vec_i != 0, the block SHALL load pending=vec_i, clear count_o, and enter SCAN next cycle.
REQ-019 On vec_valid_i & vec_ready_o with vec_i == 0, the block SHALL discard the vector, stay in IDLE, emit nothing, and clear count_o.
REQ-020 In SCAN, idx_valid_o SHALL be 1 and busy_o SHALL be 1; in IDLE, both SHALL be 0.
REQ-021 When MODE=0, idx_o SHALL be the lowest set bit position of pending; when MODE=1, the highest set bit position (WIDTH-1 minus leading-zero count).
REQ-022 last_o SHALL be 1 in SCAN iff pending has exactly one set bit.
REQ-023 When idx_valid_o=0, idx_o and last_o SHALL be 0.
REQ-024 idx_o and last_o SHALL remain stable while idx_valid_o=1 and idx_ready_i=0.
REQ-025 On an idx handshake, the block SHALL clear bit idx_o in pending and increment count_o; if last_o=1, it SHALL return to IDLE next cycle.
REQ-026 Latency: a vector accepted in cycle N SHALL present its first index in cycle N+1; with idx_ready_i held at 1, a vector with k set bits SHALL emit one index per cycle for k cycles.
REQ-027 The next vector SHALL be accepted no earlier than the cycle after the last handshake; there is no same-cycle accept in SCAN.
REQ-028 flush_i SHALL take priority over every handshake; the next state SHALL be IDLE with pending=0 and count_o=0, and any idx handshake in that cycle SHALL be ignored.
REQ-029 For WIDTH=1, idx_o SHALL be constant 0 and any nonzero vector SHALL emit a single index with last_o=1.
REQ-030 count_o SHALL hold its value in IDLE until the next accept, flush, or reset.

Reset
REQ-031 While rst_i=1, the block SHALL immediately force state=IDLE, pending=0, count_o=0, idx_valid_o=0, idx_o=0, last_o=0, busy_o=0, and vec_ready_o=1 (subject to flush_i per REQ-017).
REQ-032 Reset asserted mid-SCAN SHALL abandon the vector with no further index emitted after release.

Verification
REQ-033 WIDTH=8, MODE=0, vec_i=8'b1010_0101, idx_ready_i=1 -> idx_o 0,2,5,7 on cycles N+1..N+4, last_o=1 only with 7, vec_ready_o=1 at N+5, count_o=4.
REQ-034 Same stimulus with MODE=1 -> idx_o 7,5,2,0, last_o with 0.
REQ-035 MODE=0, vec_i=8'hFF, idx_ready_i=0 for 3 cycles while idx_o=2 -> idx_o=2 and idx_valid_o=1 held stable; after release, 3..7 emitted, count_o=8.
REQ-036 vec_i=8'h00 accepted -> idx_valid_o stays 0, busy_o stays 0, vec_ready_o stays 1, count_o=0.
REQ-037 vec_i=8'hF0 (MODE=0), flush_i pulsed during the handshake of idx 5 -> next cycle IDLE, idx_valid_o=0, count_o=0, and idx 6/7 never emitted.
REQ-038 rst_i asserted mid-scan of 8'h81, then released, then vec_i=8'h80 -> outputs at reset values during reset; single idx_o=7 with last_o=1 on the first index.
